// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode encodings, unit selects and the
// result-entry layout shared by the result collector.
package alu_pkg;

  localparam int ALU_W = 16;

  typedef enum logic [3:0] {
    FUN_ADD     = 4'b0000,
    FUN_SUB     = 4'b0001,
    FUN_MUL     = 4'b0010,
    FUN_DIV     = 4'b0011,
    FUN_AND     = 4'b0100,
    FUN_OR      = 4'b0101,
    FUN_NAND    = 4'b0110,
    FUN_NOR     = 4'b0111,
    FUN_CMP_NOP = 4'b1000,
    FUN_CMP_GT  = 4'b1001,
    FUN_CMP_LT  = 4'b1010,
    FUN_CMP_EQ  = 4'b1011,
    FUN_LSL     = 4'b1100,
    FUN_LSR     = 4'b1101,
    FUN_ASL     = 4'b1110,
    FUN_ASR     = 4'b1111
  } alu_fun_e;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  typedef struct packed {
    logic [3:0]              fun;
    logic                    flag;
    logic signed [ALU_W-1:0] data;
  } res_entry_t;

  function automatic logic [1:0] unit_of(
    input logic [3:0] fun
  );
    return fun[3:2];
  endfunction

endpackage

// File: rtl/alu_result_collector_if.sv
// Result stream of the collector: valid/ready handshake
// carrying {data, fun, flag}; master = collector side.
interface alu_result_collector_if #(
  parameter int WIDTH = 16
);
  logic                    res_valid;
  logic                    res_ready;
  logic signed [WIDTH-1:0] res_data;
  logic [3:0]              res_fun;
  logic                    res_flag;

  modport master (
    output res_valid, res_data, res_fun, res_flag,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_data, res_fun, res_flag,
    output res_ready
  );
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: sync circular FIFO, pointers with wrap bit.
// Ports: push/din in, pop/dout/valid out, count = occupancy.
module alu_result_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign count = wr_ptr - rd_ptr;
  assign valid = wr_ptr != rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot the push takes.
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst)
    !(push && full && !do_pop)
  );

endmodule

// File: rtl/alu_result_collector.sv
// alu_result_collector: tags ALU issues, captures unit output
// ALU_LAT cycles later into a credit-protected result FIFO.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 16,
  parameter  int DEPTH   = 4,
  parameter  int ALU_LAT = 1,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic [3:0]              issue_fun,
  output logic                    issue_ready,
  input  logic signed [WIDTH-1:0] Arith_Out,
  input  logic signed [WIDTH-1:0] Logic_Out,
  input  logic signed [WIDTH-1:0] CMP_Out,
  input  logic signed [WIDTH-1:0] Shift_Out,
  input  logic                    Arith_Flag,
  input  logic                    Logic_Flag,
  input  logic                    CMP_Flag,
  input  logic                    Shift_Flag,
  alu_result_collector_if.master  res,
  output logic [CW-1:0]           res_count,
  output logic                    unit_err
);

  logic [ALU_LAT-1:0]      tag_v;
  logic [3:0]              tag_f [ALU_LAT];
  logic                    issue;
  logic                    cap_v;
  logic [3:0]              cap_f;
  logic                    sel_flag;
  logic signed [WIDTH-1:0] sel_data;
  logic                    pop;
  res_entry_t              push_e;
  res_entry_t              head_e;
  int                      inflight;

  assign issue = issue_valid && issue_ready;
  assign cap_v = tag_v[ALU_LAT-1];
  assign cap_f = tag_f[ALU_LAT-1];

  always_comb begin
    inflight = 0;
    for (int i = 0; i < ALU_LAT; i++) begin
      inflight += tag_v[i] ? 1 : 0;
    end
  end

  // Credit covers both stored and in-flight results.
  assign issue_ready =
    (int'(res_count) + inflight) < DEPTH;

  always_comb begin
    sel_data = Arith_Out;
    sel_flag = Arith_Flag;
    unique case (unit_of(cap_f))
      UNIT_ARITH: begin
        sel_data = Arith_Out;
        sel_flag = Arith_Flag;
      end
      UNIT_LOGIC: begin
        sel_data = Logic_Out;
        sel_flag = Logic_Flag;
      end
      UNIT_CMP: begin
        sel_data = CMP_Out;
        sel_flag = CMP_Flag;
      end
      UNIT_SHIFT: begin
        sel_data = Shift_Out;
        sel_flag = Shift_Flag;
      end
    endcase
  end

  always_comb begin
    push_e      = '0;
    push_e.fun  = cap_f;
    push_e.flag = sel_flag;
    push_e.data = sel_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v    <= '0;
      unit_err <= 1'b0;
      for (int i = 0; i < ALU_LAT; i++) begin
        tag_f[i] <= '0;
      end
    end else begin
      tag_v[0] <= issue;
      tag_f[0] <= issue ? issue_fun : 4'd0;
      for (int i = 1; i < ALU_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_f[i] <= tag_f[i-1];
      end
      if (cap_v && !sel_flag) begin
        unit_err <= 1'b1;
      end
    end
  end

  assign pop = res.res_valid && res.res_ready;

  alu_result_fifo #(
    .W     ($bits(res_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap_v),
    .din   (push_e),
    .pop   (pop),
    .dout  (head_e),
    .valid (res.res_valid),
    .count (res_count)
  );

  assign res.res_data = head_e.data;
  assign res.res_fun  = head_e.fun;
  assign res.res_flag = head_e.flag;

  a_valid_known: assert property (
    @(posedge clk) disable iff (!rst)
    !$isunknown(issue_valid)
  );

  a_fun_known: assert property (
    @(posedge clk) disable iff (!rst)
    issue |-> !$isunknown(issue_fun)
  );

endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector: queue-based reference model plus
// vector table and directed corner sequences.
module tb_alu_result_collector;
  import alu_pkg::*;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int L  = 1;
  localparam int L3 = 3;

  typedef struct {
    logic [3:0] fun;
    logic       flag;
    int         data;
  } ent_t;

  typedef struct {
    logic [3:0] fun;
    int         cap;
  } tag_t;

  typedef struct {
    logic [3:0] fun;
    int         a;
    int         l;
    int         c;
    int         s;
    int         exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic issue_valid;
  logic [3:0] issue_fun;
  logic signed [W-1:0] a_out, l_out, c_out, s_out;
  logic a_f, l_f, c_f, s_f;
  logic rdy;
  logic issue_ready, issue_ready3;
  logic uerr, uerr3;
  logic [2:0] cnt, cnt3;

  alu_result_collector_if #(.WIDTH(W)) rif ();
  alu_result_collector_if #(.WIDTH(W)) rif3 ();

  assign rif.res_ready  = rdy;
  assign rif3.res_ready = rdy;

  always #5 clk = ~clk;

  alu_result_collector #(
    .WIDTH(W), .DEPTH(D), .ALU_LAT(L)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid),
    .issue_fun(issue_fun),
    .issue_ready(issue_ready),
    .Arith_Out(a_out), .Logic_Out(l_out),
    .CMP_Out(c_out), .Shift_Out(s_out),
    .Arith_Flag(a_f), .Logic_Flag(l_f),
    .CMP_Flag(c_f), .Shift_Flag(s_f),
    .res(rif.master),
    .res_count(cnt),
    .unit_err(uerr)
  );

  alu_result_collector #(
    .WIDTH(W), .DEPTH(D), .ALU_LAT(L3)
  ) dut3 (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid),
    .issue_fun(issue_fun),
    .issue_ready(issue_ready3),
    .Arith_Out(a_out), .Logic_Out(l_out),
    .CMP_Out(c_out), .Shift_Out(s_out),
    .Arith_Flag(a_f), .Logic_Flag(l_f),
    .CMP_Flag(c_f), .Shift_Flag(s_f),
    .res(rif3.master),
    .res_count(cnt3),
    .unit_err(uerr3)
  );

  int   n_run;
  int   n_fail;
  int   cyc;
  bit   merr;
  ent_t expq[$];
  tag_t pend[$];

  function automatic void chk(
    input string name, input int got, input int exp
  );
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               name, got, exp);
    end
  endfunction

  function automatic ent_t pick(input logic [3:0] f);
    ent_t e;
    e.fun = f;
    case (f[3:2])
      2'b00:   begin e.data = int'(a_out); e.flag = a_f; end
      2'b01:   begin e.data = int'(l_out); e.flag = l_f; end
      2'b10:   begin e.data = int'(c_out); e.flag = c_f; end
      default: begin e.data = int'(s_out); e.flag = s_f; end
    endcase
    return e;
  endfunction

  function automatic int room();
    return ((expq.size() + pend.size()) < D) ? 1 : 0;
  endfunction

  task automatic check_state();
    chk("issue_ready", int'(issue_ready), room());
    chk("res_valid", int'(rif.res_valid),
        (expq.size() > 0) ? 1 : 0);
    chk("res_count", int'(cnt), expq.size());
    chk("unit_err", int'(uerr), int'(merr));
    if (expq.size() > 0) begin
      chk("res_data", int'(rif.res_data), expq[0].data);
      chk("res_fun", int'(rif.res_fun), int'(expq[0].fun));
      chk("res_flag", int'(rif.res_flag),
          int'(expq[0].flag));
    end
  endtask

  // One clock: check, advance model with current inputs.
  task automatic tick();
    bit   acc;
    ent_t e;
    check_state();
    acc = issue_valid && (room() == 1);
    if (rdy && expq.size() > 0) void'(expq.pop_front());
    if (pend.size() > 0 && pend[0].cap == cyc) begin
      e = pick(pend[0].fun);
      if (!e.flag) merr = 1'b1;
      expq.push_back(e);
      void'(pend.pop_front());
    end
    if (acc) pend.push_back('{issue_fun, cyc + L});
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic units(input int a, l, c, s);
    a_out = W'(a);
    l_out = W'(l);
    c_out = W'(c);
    s_out = W'(s);
    a_f = 1'b1; l_f = 1'b1; c_f = 1'b1; s_f = 1'b1;
  endtask

  task automatic rnd_units();
    units(int'($urandom), int'($urandom),
          int'($urandom), int'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    issue_valid = 1'b0;
    issue_fun = 4'd0;
    rdy = 1'b0;
    units(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    expq.delete();
    pend.delete();
    merr = 1'b0;
  endtask

  initial begin
    vec_t tbl[8];
    int   got[$];
    int   gotc[$];
    int   acc;

    n_run = 0;
    n_fail = 0;
    cyc = 0;
    merr = 1'b0;
    rst = 1'b0;
    issue_valid = 1'b0;
    issue_fun = 4'd0;
    rdy = 1'b0;
    units(0, 0, 0, 0);

    tbl = '{
      '{FUN_ADD,     15,  -1,  3,   7,  15},
      '{FUN_SUB,      5,   9, -2,  11,   5},
      '{FUN_MUL,     12,   1,  4,  -6,  12},
      '{FUN_CMP_GT,  77,  33,  1,  -9,   1},
      '{FUN_ASR,    100, -50,  2,  -4,  -4},
      '{FUN_AND,      6,   0,  8,  13,   0},
      '{FUN_OR,       6,  15,  8,  13,  15},
      '{FUN_LSL,      3,   3,  3,  20,  20}
    };

    // Reset values while rst is held low
    @(negedge clk);
    chk("rst issue_ready", int'(issue_ready), 1);
    chk("rst res_valid", int'(rif.res_valid), 0);
    chk("rst res_data", int'(rif.res_data), 0);
    chk("rst res_fun", int'(rif.res_fun), 0);
    chk("rst res_flag", int'(rif.res_flag), 0);
    chk("rst res_count", int'(cnt), 0);
    chk("rst unit_err", int'(uerr), 0);
    do_reset();

    // Single ADD: visible two cycles after issue
    rdy = 1'b1;
    issue_valid = 1'b1;
    issue_fun = FUN_ADD;
    tick();
    issue_valid = 1'b0;
    units(15, -3, 9, 40);
    tick();
    chk("add valid", int'(rif.res_valid), 1);
    chk("add data", int'(rif.res_data), 15);
    chk("add fun", int'(rif.res_fun), 0);
    chk("add flag", int'(rif.res_flag), 1);
    units(0, 0, 0, 0);
    tick();

    // Back-to-back table vectors
    for (int k = 0; k < 8 + L + 2; k++) begin
      if (rif.res_valid) begin
        got.push_back(int'(rif.res_data));
        gotc.push_back(k);
      end
      issue_valid = (k < 8);
      issue_fun = 4'd0;
      if (k < 8) issue_fun = tbl[k].fun;
      units(16'h1234, 16'h2345, 16'h3456, 16'h4567);
      if (k >= L && k - L < 8) begin
        units(tbl[k-L].a, tbl[k-L].l,
              tbl[k-L].c, tbl[k-L].s);
      end
      tick();
    end
    chk("tbl results", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) begin
        chk("tbl data", got[i], tbl[i].exp);
        chk("tbl cycle", gotc[i], i + L + 1);
      end
    end

    // Backpressure: exactly DEPTH issues accepted
    issue_valid = 1'b0;
    rdy = 1'b0;
    tick();
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      issue_valid = 1'b1;
      issue_fun = 4'(k);
      rnd_units();
      if (issue_ready) acc++;
      tick();
    end
    chk("bp accepted", acc, 4);
    chk("bp issue_ready", int'(issue_ready), 0);
    chk("bp count", int'(cnt), 4);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("credit release", int'(issue_ready), 1);
    chk("credit count", int'(cnt), 3);
    issue_fun = FUN_NOR;
    tick();
    issue_valid = 1'b0;
    rnd_units();
    tick();
    chk("bp fifth lands", int'(cnt), 4);
    chk("bp full again", int'(issue_ready), 0);
    rdy = 1'b1;
    repeat (6) tick();

    // Streaming through pointer wrap
    for (int k = 0; k < 14; k++) begin
      issue_valid = 1'b1;
      issue_fun = 4'($urandom);
      rnd_units();
      tick();
    end
    issue_valid = 1'b0;
    repeat (4) tick();

    // Flag mismatch on the logic unit
    chk("err before", int'(uerr), 0);
    rdy = 1'b0;
    issue_valid = 1'b1;
    issue_fun = FUN_AND;
    tick();
    issue_valid = 1'b0;
    units(-7, 33, 5, 6);
    l_f = 1'b0;
    tick();
    l_f = 1'b1;
    chk("mis valid", int'(rif.res_valid), 1);
    chk("mis data", int'(rif.res_data), 33);
    chk("mis flag", int'(rif.res_flag), 0);
    chk("mis fun", int'(rif.res_fun), 4);
    chk("unit_err set", int'(uerr), 1);
    rdy = 1'b1;
    repeat (4) tick();
    chk("unit_err sticky", int'(uerr), 1);
    do_reset();
    chk("unit_err cleared", int'(uerr), 0);

    // Randomized traffic against the queue model
    for (int k = 0; k < 400; k++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_fun = 4'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      rnd_units();
      a_f = ($urandom_range(0, 15) != 0);
      l_f = ($urandom_range(0, 15) != 0);
      c_f = ($urandom_range(0, 15) != 0);
      s_f = ($urandom_range(0, 15) != 0);
      tick();
    end

    // Reset mid-operation on the ALU_LAT=3 instance
    do_reset();
    for (int k = 0; k < 4; k++) begin
      issue_valid = 1'b1;
      issue_fun = 4'($urandom);
      rnd_units();
      tick();
    end
    issue_valid = 1'b0;
    rnd_units();
    tick();
    chk("r3 count", int'(cnt3), 2);
    chk("r3 ready", int'(issue_ready3), 0);
    chk("r3 valid", int'(rif3.res_valid), 1);
    rst = 1'b0;
    #1;
    chk("r3 async valid", int'(rif3.res_valid), 0);
    chk("r3 async count", int'(cnt3), 0);
    chk("r3 async ready", int'(issue_ready3), 1);
    chk("r3 async data", int'(rif3.res_data), 0);
    chk("r3 async fun", int'(rif3.res_fun), 0);
    chk("r3 async flag", int'(rif3.res_flag), 0);
    chk("r3 async err", int'(uerr3), 0);
    #2;
    rst = 1'b1;
    expq.delete();
    pend.delete();
    merr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("r3 no result", int'(rif3.res_valid), 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
